// File: rtl/uc_pkg.sv
// Shared opcode, state and ALU-operation constants for the uc_seq control unit.
package uc_pkg;

    localparam logic [5:0] OP_NOP        = 6'b000000;
    localparam logic [2:0] OP_ALU_PREFIX = 3'b001;
    localparam logic [5:0] OP_LI         = 6'b010000;
    localparam logic [5:0] OP_J          = 6'b100000;
    localparam logic [5:0] OP_JZ         = 6'b100001;
    localparam logic [5:0] OP_JNZ        = 6'b100010;
    localparam logic [5:0] OP_WAIT       = 6'b110000;
    localparam logic [5:0] OP_HALT       = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HALT
    } uc_state_e;

    // ALU operation codes, carried straight from opcode[2:0] to the alu block
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b100;
    localparam logic [2:0] ALU_NOT_A  = 3'b101;
    localparam logic [2:0] ALU_PASS_A = 3'b110;
    localparam logic [2:0] ALU_PASS_B = 3'b111;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_NOP) || (op[5:3] == OP_ALU_PREFIX) || (op == OP_LI) ||
               (op == OP_J) || (op == OP_JZ) || (op == OP_JNZ) ||
               (op == OP_WAIT) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// 8-bit load/decrement down-counter with zero flag; times the WAIT stall.
module wait_timer (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       dec_i,
    input  logic [7:0] load_val_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit for the cd datapath: opcode decode plus IDLE/RUN/WAIT/HALT run control.
// Optional build macro UC_ILLEGAL_TRAP_EN turns illegal opcodes into a HALT-style trap.
module uc_seq
    import uc_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op_alu,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

    uc_state_e        state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmr_load, tmr_dec, tmr_zero;

    wait_timer u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (WAIT_LOAD),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        s_inc     = 1'b0;
        s_inm     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        op_alu    = ALU_ADD;
        pc_en     = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        state_d   = state_q;
        illegal_d = illegal_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                s_inc = 1'b1;
                if (opcode == OP_WAIT) begin
                    tmr_load = 1'b1;
                    state_d  = S_WAIT;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (!op_is_legal(opcode)) begin
                    illegal_d = 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    pc_en = 1'b1;
`endif
                end else begin
                    pc_en = 1'b1;
                    if (opcode[5:3] == OP_ALU_PREFIX) begin
                        we3    = 1'b1;
                        wez    = 1'b1;
                        op_alu = opcode[2:0];
                    end
                    case (opcode)
                        OP_LI: begin
                            s_inm = 1'b1;
                            we3   = 1'b1;
                        end
                        OP_J:    s_inc = 1'b0;
                        OP_JZ:   s_inc = ~z;
                        OP_JNZ:  s_inc = z;
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                s_inc = 1'b1;
                // WAIT retires on the exit cycle, so the PC only moves here
                if (tmr_zero) begin
                    pc_en   = 1'b1;
                    state_d = S_RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_HALT: begin
                s_inc = 1'b1;
                if (start) begin
                    pc_en   = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = (pc_en && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            halted_q  <= (state_d == S_HALT);
            cnt_q     <= cnt_d;
        end
    end

    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_seq.sv
// Randomized self-checking bench for uc_seq against a behavioural run-control model.
module tb_uc_seq;

    localparam int unsigned WAIT_CYCLES = 4;

    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_WAIT = 2;
    localparam int MODE_HALT = 3;

    localparam int C_NOP = 0, C_ALU = 1, C_LI = 2, C_J = 3, C_JZ = 4, C_JNZ = 5;
    localparam int C_WAIT = 6, C_HALT = 7, C_ILL = 8;

`ifdef UC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic       z;

    logic        a_s_inc, a_s_inm, a_we3, a_wez, a_pc_en, a_halted, a_illegal;
    logic [2:0]  a_op_alu;
    logic [15:0] a_cnt;
    logic        b_s_inc, b_s_inm, b_we3, b_wez, b_pc_en, b_halted, b_illegal;
    logic [2:0]  b_op_alu;
    logic [2:0]  b_cnt;

    uc_seq #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .z(z),
        .s_inc(a_s_inc), .s_inm(a_s_inm), .we3(a_we3), .wez(a_wez),
        .op_alu(a_op_alu), .pc_en(a_pc_en), .halted(a_halted),
        .illegal(a_illegal), .instr_count(a_cnt)
    );

    uc_seq #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .z(z),
        .s_inc(b_s_inc), .s_inm(b_s_inm), .we3(b_we3), .wez(b_wez),
        .op_alu(b_op_alu), .pc_en(b_pc_en), .halted(b_halted),
        .illegal(b_illegal), .instr_count(b_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int          m_mode;
    int          m_seen;
    bit          m_ill;
    int unsigned m_cnt;
    int unsigned m_cnt3;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        if (op == 6'o00)                   return C_NOP;
        if (op >= 6'o10 && op <= 6'o17)    return C_ALU;
        if (op == 6'o20)                   return C_LI;
        if (op == 6'o40)                   return C_J;
        if (op == 6'o41)                   return C_JZ;
        if (op == 6'o42)                   return C_JNZ;
        if (op == 6'o60)                   return C_WAIT;
        if (op == 6'o77)                   return C_HALT;
        return C_ILL;
    endfunction

    task automatic model_reset();
        m_mode = MODE_IDLE;
        m_seen = 0;
        m_ill  = 1'b0;
        m_cnt  = 0;
        m_cnt3 = 0;
    endtask

    task automatic cycle(input bit r, input bit s, input logic [5:0] op, input bit zz);
        int c;
        bit e_pc, e_inc, e_we3, e_wez, e_inm;
        int unsigned e_alu;
        reset  = r;
        start  = s;
        opcode = op;
        z      = zz;
        c      = classify(op);
        e_pc = 0; e_inc = 0; e_we3 = 0; e_wez = 0; e_inm = 0; e_alu = 0;
        case (m_mode)
            MODE_RUN: begin
                e_pc  = !(c == C_WAIT || c == C_HALT || (c == C_ILL && TRAP));
                e_inc = (c == C_J) ? 1'b0 : (c == C_JZ) ? !zz : (c == C_JNZ) ? zz : 1'b1;
                e_we3 = (c == C_ALU) || (c == C_LI);
                e_wez = (c == C_ALU);
                e_inm = (c == C_LI);
                e_alu = (c == C_ALU) ? int'(op) % 8 : 0;
            end
            MODE_WAIT: begin
                e_inc = 1'b1;
                e_pc  = (m_seen == int'(WAIT_CYCLES));
            end
            MODE_HALT: begin
                e_inc = 1'b1;
                e_pc  = s;
            end
            default: ;
        endcase

        @(negedge clk);
        check("pc_en",   a_pc_en,   e_pc);
        check("s_inc",   a_s_inc,   e_inc);
        check("we3",     a_we3,     e_we3);
        check("wez",     a_wez,     e_wez);
        check("s_inm",   a_s_inm,   e_inm);
        check("op_alu",  a_op_alu,  e_alu);
        check("halted",  a_halted,  m_mode == MODE_HALT);
        check("illegal", a_illegal, m_ill);
        check("count",   a_cnt,     m_cnt);
        check("count3",  b_cnt,     m_cnt3);
        check("pc_en3",  b_pc_en,   e_pc);

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (e_pc) begin
                if (m_cnt < 32'hFFFF) m_cnt++;
                if (m_cnt3 < 7) m_cnt3++;
            end
            case (m_mode)
                MODE_IDLE: if (s) m_mode = MODE_RUN;
                MODE_RUN: begin
                    if (c == C_ILL) m_ill = 1'b1;
                    if (c == C_WAIT) begin
                        m_mode = MODE_WAIT;
                        m_seen = 1;
                    end else if (c == C_HALT || (c == C_ILL && TRAP)) begin
                        m_mode = MODE_HALT;
                    end
                end
                MODE_WAIT: begin
                    if (m_seen == int'(WAIT_CYCLES)) m_mode = MODE_RUN;
                    else m_seen++;
                end
                MODE_HALT: if (s) m_mode = MODE_RUN;
                default: ;
            endcase
        end
        #1;
    endtask

    logic [5:0] legal_ops [10];

    initial begin
        legal_ops = '{6'o00, 6'o12, 6'o17, 6'o20, 6'o40, 6'o41, 6'o42, 6'o60, 6'o77, 6'o13};
        reset  = 1'b1;
        start  = 1'b0;
        opcode = '0;
        z      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, then start and basic decode
        cycle(1, 0, 6'o00, 0);
        cycle(0, 0, 6'o00, 0);
        cycle(0, 1, 6'o00, 0);
        cycle(0, 0, 6'b001010, 0);
        cycle(0, 0, 6'o41, 1);
        cycle(0, 0, 6'o41, 0);
        cycle(0, 0, 6'o42, 1);
        cycle(0, 0, 6'o42, 0);
        cycle(0, 0, 6'o40, 0);
        cycle(0, 0, 6'o20, 0);
        cycle(0, 1, 6'o00, 0);

        // WAIT stall
        cycle(0, 0, 6'o60, 0);
        repeat (WAIT_CYCLES) cycle(0, 1, 6'o00, 0);
        cycle(0, 0, 6'o00, 0);

        // HALT held, then resumed
        cycle(0, 0, 6'o77, 0);
        repeat (10) cycle(0, 0, 6'o00, 0);
        cycle(0, 1, 6'o00, 0);
        cycle(0, 0, 6'o00, 0);

        // illegal opcode, sticky flag
        cycle(0, 0, 6'b011111, 0);
        cycle(0, 0, 6'o00, 0);
        cycle(0, 1, 6'o00, 0);
        repeat (3) cycle(0, 0, 6'o12, 0);

        // reset together with start on the second WAIT cycle
        cycle(0, 0, 6'o60, 0);
        cycle(0, 0, 6'o00, 0);
        cycle(1, 1, 6'o00, 0);
        cycle(0, 0, 6'o00, 0);
        cycle(0, 1, 6'o00, 0);

        repeat (1500) begin
            logic [5:0] op;
            bit r, s;
            r  = ($urandom % 80) == 0;
            s  = ($urandom % 6) == 0;
            if (($urandom % 5) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom % 10];
            cycle(r, s, op, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
